// File: rtl/dcache_pkg.sv
// Shared types, constants and address-field helpers for the data cache controller.
package dcache_pkg;

  localparam int unsigned WORDS_PER_LINE = 4;
  localparam int unsigned OFFSET_BITS    = 4;
  localparam int unsigned ADDR_MAX       = 64;

  // Legacy state encodings kept so existing decode tables still line up.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REFILL = 2'd1;
  localparam logic [1:0] ST_WRITE  = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    REFILL = ST_REFILL,
    WRITE  = ST_WRITE
  } state_t;

  // Line index: the INDEX_BITS just above the byte/word offset.
  function automatic logic [ADDR_MAX-1:0] addr_index(input logic [ADDR_MAX-1:0] addr,
                                                     input int unsigned index_bits);
    logic [ADDR_MAX-1:0] mask;
    mask = (ADDR_MAX'(1) << index_bits) - ADDR_MAX'(1);
    return (addr >> OFFSET_BITS) & mask;
  endfunction

  // Tag: everything above the index.
  function automatic logic [ADDR_MAX-1:0] addr_tag(input logic [ADDR_MAX-1:0] addr,
                                                   input int unsigned index_bits);
    return addr >> (OFFSET_BITS + index_bits);
  endfunction

  // Word slot within the 4-word line.
  function automatic logic [1:0] addr_word(input logic [ADDR_MAX-1:0] addr);
    return 2'(addr >> 2);
  endfunction

endpackage

// File: rtl/dcache_ctrl_if.sv
// CPU-side access and memory-side handshake bundle of the data cache controller.
interface dcache_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LINES      = 8
);
  localparam int unsigned INDEX_BITS = $clog2(LINES);

  logic                  cpu_req;
  logic                  cpu_we;
  logic [DATA_WIDTH-1:0] cpu_addr;
  logic                  flush;
  logic                  stall;
  logic                  hit;
  logic                  cache_we;
  logic                  fill_we;
  logic [1:0]            fill_word;
  logic [INDEX_BITS-1:0] fill_index;
  logic                  mem_req;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic                  mem_ready;

  // Environment side: CPU requests plus the memory's ready response.
  modport master (
    output cpu_req, cpu_we, cpu_addr, flush, mem_ready,
    input  stall, hit, cache_we, fill_we, fill_word, fill_index,
           mem_req, mem_we, mem_addr
  );

  // Controller side.
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, flush, mem_ready,
    output stall, hit, cache_we, fill_we, fill_word, fill_index,
           mem_req, mem_we, mem_addr
  );
endinterface

// File: rtl/dcache_tag_store.sv
// Valid bits and tag array for a direct-mapped cache: one read port, one write port.
module dcache_tag_store #(
  parameter int unsigned LINES    = 8,
  parameter int unsigned TAG_BITS = 25
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic [$clog2(LINES)-1:0] rd_index,
  output logic                     rd_valid,
  output logic [TAG_BITS-1:0]      rd_tag,
  input  logic                     wr_en,
  input  logic [$clog2(LINES)-1:0] wr_index,
  input  logic [TAG_BITS-1:0]      wr_tag
);
  logic [LINES-1:0]    valid;
  logic [TAG_BITS-1:0] tags [LINES];

  // Valid bits: async reset, synchronous flush, set on line fill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        valid <= '0;
    else if (clear) valid <= '0;
    else if (wr_en) valid[wr_index] <= 1'b1;
  end

  // Tag array is not reset; the valid bits gate any stale contents.
  always_ff @(posedge clk) begin
    if (wr_en) tags[wr_index] <= wr_tag;
  end

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tags[rd_index];
endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-through data cache controller: lookup, 4-word refill, store write-through.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LINES      = 8
) (
  input logic          clk,
  input logic          rst,
  dcache_ctrl_if.slave bus
);
  localparam int unsigned INDEX_BITS = $clog2(LINES);
  localparam int unsigned TAG_BITS   = DATA_WIDTH - OFFSET_BITS - INDEX_BITS;

  state_t                state, state_n;
  logic [1:0]            cnt, cnt_n;
  logic                  hit_q, hit_q_n;
  logic [INDEX_BITS-1:0] index;
  logic [TAG_BITS-1:0]   tag;
  logic                  rd_valid;
  logic [TAG_BITS-1:0]   rd_tag;
  logic                  lookup;
  logic                  flush_clr, tag_we;

  assign index  = INDEX_BITS'(addr_index(ADDR_MAX'(bus.cpu_addr), INDEX_BITS));
  assign tag    = TAG_BITS'(addr_tag(ADDR_MAX'(bus.cpu_addr), INDEX_BITS));
  assign lookup = bus.cpu_req & rd_valid & (rd_tag == tag);

  dcache_tag_store #(
    .LINES    (LINES),
    .TAG_BITS (TAG_BITS)
  ) u_tags (
    .clk      (clk),
    .rst      (rst),
    .clear    (flush_clr),
    .rd_index (index),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .wr_en    (tag_we),
    .wr_index (index),
    .wr_tag   (tag)
  );

  // State, refill beat counter and latched store-hit flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      hit_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      hit_q <= hit_q_n;
    end
  end

  // Next state and outputs; everything is held low while reset is asserted.
  always_comb begin
    state_n        = state;
    cnt_n          = cnt;
    hit_q_n        = hit_q;
    flush_clr      = 1'b0;
    tag_we         = 1'b0;
    bus.stall      = 1'b0;
    bus.hit        = 1'b0;
    bus.cache_we   = 1'b0;
    bus.fill_we    = 1'b0;
    bus.fill_word  = '0;
    bus.fill_index = '0;
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = '0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (bus.flush) begin
            // Flush takes priority; a pending access is retried after the clear.
            flush_clr = 1'b1;
            bus.stall = bus.cpu_req;
          end else if (bus.cpu_req) begin
            bus.hit = lookup;
            if (bus.cpu_we) begin
              bus.stall = 1'b1;
              hit_q_n   = lookup;
              state_n   = WRITE;
            end else if (!lookup) begin
              bus.stall = 1'b1;
              cnt_n     = '0;
              state_n   = REFILL;
            end
          end
        end
        REFILL: begin
          bus.mem_req  = 1'b1;
          bus.stall    = 1'b1;
          bus.mem_addr = {bus.cpu_addr[DATA_WIDTH-1:OFFSET_BITS], cnt, 2'b00};
          if (bus.mem_ready) begin
            bus.fill_we    = 1'b1;
            bus.fill_word  = cnt;
            bus.fill_index = index;
            cnt_n          = cnt + 2'd1;
            if (cnt == 2'(WORDS_PER_LINE - 1)) begin
              tag_we  = 1'b1;
              state_n = IDLE;
            end
          end
        end
        WRITE: begin
          bus.mem_req  = 1'b1;
          bus.mem_we   = 1'b1;
          bus.stall    = 1'b1;
          bus.mem_addr = {bus.cpu_addr[DATA_WIDTH-1:2], 2'b00};
          if (bus.mem_ready) begin
            bus.stall      = 1'b0;
            bus.cache_we   = hit_q;
            bus.fill_index = index;
            state_n        = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: directed accesses, decoupled monitor.
module tb_dcache_ctrl;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic        fill_we;
    logic [1:0]  word;
    logic [2:0]  idx;
    logic        cache_we;
  } mem_ev_t;

  typedef struct packed {
    logic       hit;
    logic [7:0] stalls;
  } cpu_ev_t;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   mem_delay = 0;

  mem_ev_t mem_q[$];
  cpu_ev_t cpu_q[$];

  dcache_ctrl_if #(.DATA_WIDTH(32), .LINES(8)) bus ();

  dcache_ctrl #(.DATA_WIDTH(32), .LINES(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Memory responder: mem_ready rises after mem_delay waiting cycles per request beat.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    bus.mem_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!bus.mem_req) begin
        wait_cnt = 0;
        bus.mem_ready = (mem_delay == 0);
      end else begin
        bus.mem_ready = (wait_cnt >= mem_delay);
        wait_cnt = bus.mem_ready ? 0 : wait_cnt + 1;
      end
    end
  end

  // Monitor: compares memory handshakes and CPU completions against the queues.
  initial begin
    int      stall_cnt;
    mem_ev_t act, exp_m;
    cpu_ev_t act_c, exp_c;
    stall_cnt = 0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        stall_cnt = 0;
      end else begin
        if (bus.mem_req && bus.mem_ready) begin
          act.we = bus.mem_we;
          act.addr = bus.mem_addr;
          act.fill_we = bus.fill_we;
          act.word = bus.fill_word;
          act.idx = bus.fill_index;
          act.cache_we = bus.cache_we;
          checks++;
          if (mem_q.size() == 0) begin
            errors++;
            $display("FAIL mem_unexpected: actual=%h required=none", act);
          end else begin
            exp_m = mem_q.pop_front();
            if (act !== exp_m) begin
              errors++;
              $display("FAIL mem_event: actual we=%b addr=%h fw=%b word=%0d idx=%0d cwe=%b required we=%b addr=%h fw=%b word=%0d idx=%0d cwe=%b",
                       act.we, act.addr, act.fill_we, act.word, act.idx, act.cache_we,
                       exp_m.we, exp_m.addr, exp_m.fill_we, exp_m.word, exp_m.idx, exp_m.cache_we);
            end
          end
        end else if (bus.fill_we || bus.cache_we) begin
          checks++;
          errors++;
          $display("FAIL array_write_no_handshake: actual fill_we=%b cache_we=%b required 0 0",
                   bus.fill_we, bus.cache_we);
        end
        if (bus.cpu_req) begin
          if (bus.stall) begin
            stall_cnt++;
          end else begin
            act_c.hit = bus.hit;
            act_c.stalls = 8'(stall_cnt);
            stall_cnt = 0;
            checks++;
            if (cpu_q.size() == 0) begin
              errors++;
              $display("FAIL cpu_unexpected: actual hit=%b stalls=%0d required none", act_c.hit, act_c.stalls);
            end else begin
              exp_c = cpu_q.pop_front();
              if (act_c !== exp_c) begin
                errors++;
                $display("FAIL cpu_access: actual hit=%b stalls=%0d required hit=%b stalls=%0d",
                         act_c.hit, act_c.stalls, exp_c.hit, exp_c.stalls);
              end
            end
          end
        end
      end
    end
  end

  function automatic void push_mem(input logic we, input logic [31:0] addr, input logic fw,
                                   input logic [1:0] word, input logic [2:0] idx, input logic cwe);
    mem_ev_t e;
    e.we = we; e.addr = addr; e.fill_we = fw; e.word = word; e.idx = idx; e.cache_we = cwe;
    mem_q.push_back(e);
  endfunction

  function automatic void push_refill(input logic [31:0] base, input logic [2:0] idx);
    for (int i = 0; i < 4; i++)
      push_mem(1'b0, base + 32'(4 * i), 1'b1, 2'(i), idx, 1'b0);
  endfunction

  function automatic void push_cpu(input logic hit, input int stalls);
    cpu_ev_t e;
    e.hit = hit;
    e.stalls = 8'(stalls);
    cpu_q.push_back(e);
  endfunction

  // Called on a negedge; holds the request until stall drops, returns on a negedge.
  task automatic access(input logic we, input logic [31:0] addr, input logic fl);
    int  n;
    bit  done;
    n = 0;
    done = 1'b0;
    bus.cpu_req = 1'b1;
    bus.cpu_we = we;
    bus.cpu_addr = addr;
    bus.flush = fl;
    while (!done && n < 64) begin
      #1;
      if (!bus.stall) done = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL access_timeout addr=%h: actual=stalled required=complete", addr);
    end
    bus.cpu_req = 1'b0;
    bus.cpu_we = 1'b0;
  endtask

  task automatic check_outputs_zero(input string name);
    logic [72:0] v;
    #1;
    v = {bus.stall, bus.hit, bus.cache_we, bus.fill_we, bus.fill_word, bus.fill_index,
         bus.mem_req, bus.mem_we, bus.mem_addr, bus.fill_word, bus.fill_index, 24'h0};
    checks++;
    if (v !== '0) begin
      errors++;
      $display("FAIL %s: actual outputs=%h required=0", name, v);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.cpu_req = 1'b1;
    bus.cpu_we = 1'b0;
    bus.cpu_addr = 32'h0000_0040;
    bus.flush = 1'b0;

    // Outputs held low in reset even with a request pending.
    @(negedge clk);
    check_outputs_zero("reset_outputs");
    @(negedge clk);
    rst = 1'b0;
    bus.cpu_req = 1'b0;
    @(negedge clk);

    // Cold load miss: 4-beat refill, then hit after 5 stall cycles.
    push_refill(32'h40, 3'd4);
    push_cpu(1'b1, 5);
    access(1'b0, 32'h40, 1'b0);

    // Same line: immediate hit, no memory traffic.
    push_cpu(1'b1, 0);
    access(1'b0, 32'h44, 1'b0);

    // Conflicting tag at index 4 evicts, then the original line misses again.
    push_refill(32'h440, 3'd4);
    push_cpu(1'b1, 5);
    access(1'b0, 32'h440, 1'b0);
    push_refill(32'h40, 3'd4);
    push_cpu(1'b1, 5);
    access(1'b0, 32'h40, 1'b0);

    // Store hit with slow memory: one IDLE stall + 3 waiting cycles, cache_we once.
    mem_delay = 3;
    push_mem(1'b1, 32'h48, 1'b0, 2'd0, 3'd4, 1'b1);
    push_cpu(1'b0, 4);
    access(1'b1, 32'h4A, 1'b0);
    mem_delay = 0;

    // Store miss: write-through only, no allocation, so the next load misses.
    push_mem(1'b1, 32'h1000, 1'b0, 2'd0, 3'd0, 1'b0);
    push_cpu(1'b0, 1);
    access(1'b1, 32'h1000, 1'b0);
    push_refill(32'h1000, 3'd0);
    push_cpu(1'b1, 5);
    access(1'b0, 32'h1000, 1'b0);

    // Line 4 still holds 0x40 after the store.
    push_cpu(1'b1, 0);
    access(1'b0, 32'h4C, 1'b0);

    // Reset during the second refill beat abandons the fill.
    push_mem(1'b0, 32'h240, 1'b1, 2'd0, 3'd4, 1'b0);
    bus.cpu_req = 1'b1;
    bus.cpu_we = 1'b0;
    bus.cpu_addr = 32'h240;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    check_outputs_zero("reset_mid_refill");
    bus.cpu_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    push_refill(32'h40, 3'd4);
    push_cpu(1'b1, 5);
    access(1'b0, 32'h40, 1'b0);

    // Flush alone, then the filled line misses.
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    push_refill(32'h40, 3'd4);
    push_cpu(1'b1, 5);
    access(1'b0, 32'h40, 1'b0);

    // Flush together with a load hit: flush wins, the retried lookup misses.
    push_refill(32'h40, 3'd4);
    push_cpu(1'b1, 6);
    access(1'b0, 32'h40, 1'b1);

    repeat (4) @(negedge clk);
    checks++;
    if (mem_q.size() != 0) begin
      errors++;
      $display("FAIL mem_queue_drained: actual=%0d required=0", mem_q.size());
    end
    checks++;
    if (cpu_q.size() != 0) begin
      errors++;
      $display("FAIL cpu_queue_drained: actual=%0d required=0", cpu_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Controller for the direct-mapped data cache and the backing data memory in the load/store path.
- Holds the tag/valid store and resolves hit/miss for each CPU access.
- Sequences 4-word line refills from memory on read misses.
- Makes stores write-through and no-write-allocate, and stalls the CPU until each access completes.
- Drives the cache data-array write strobes and the memory request handshake.

Parameters:
- DATA_WIDTH, 32, word width and address width.
- LINES, 8, number of cache lines; must be a power of 2. INDEX_BITS = $clog2(LINES).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- cpu_req  in  1  load/store access valid this cycle
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  DATA_WIDTH  byte address
- flush  in  1  invalidate all lines
- stall  out  1  CPU must hold cpu_req, cpu_we and cpu_addr stable while high
- hit  out  1  lookup hit; selects cache data on the read mux
- cache_we  out  1  write one word of the cache data array (store hit)
- fill_we  out  1  write refill word into the data array
- fill_word  out  2  word slot (d0..d3) being filled
- fill_index  out  INDEX_BITS  line being filled or written
- mem_req  out  1  memory access request
- mem_we  out  1  memory write (store)
- mem_addr  out  DATA_WIDTH  memory word address
- mem_ready  in  1  memory completes the current request this cycle

Behaviour:
- Address split:
  - [1:0] byte offset (byte lanes handled by the datapath)
  - [3:2] word
  - [3+INDEX_BITS:4] index
  - upper bits tag
- Lookup (combinational): hit = cpu_req & valid[index] & (tag_ram[index] == tag). Asserted in IDLE only.
- States: IDLE, REFILL, WRITE.
- IDLE:
  - Load hit: stall=0, hit=1; stay in IDLE.
  - Load miss: stall=1; go to REFILL with cnt=0.
  - Store: stall=1; go to WRITE; latch hit_q = hit.
  - No request: all outputs 0.
- REFILL:
  - mem_req=1, mem_we=0, stall=1.
  - mem_addr = {tag, index, cnt, 2'b00}.
  - When mem_ready=1: fill_we=1, fill_word=cnt, fill_index=index, cnt++.
  - On the cycle cnt==3 with mem_ready: write tag_ram[index]=tag, set valid[index]=1, go to IDLE.
  - The re-lookup in IDLE then hits and stall drops.
  - With mem_ready tied high, miss penalty is 5 cycles: 1 IDLE + 4 REFILL, then the hit cycle.
  - A fill overwrites any valid line at that index. No dirty state exists because the cache is write-through.
- WRITE:
  - mem_req=1, mem_we=1, stall=1, mem_addr = cpu_addr with [1:0]=0.
  - When mem_ready=1: cache_we=hit_q, fill_index=index; go to IDLE with stall=0 that cycle.
  - A store miss does not allocate; valid and tag are unchanged.
- mem_ready while not requesting is ignored.
- flush:
  - Honoured only in IDLE: clears all valid bits next edge.
  - If cpu_req is also present, flush wins: stall=1 that cycle and the lookup is retried next cycle (miss).
  - flush in REFILL/WRITE is ignored; the requester holds it until stall drops.
- Reset (asynchronous, any state):
  - State goes to IDLE, cnt=0, all valid bits cleared.
  - All outputs are 0.
  - A refill in flight is abandoned; its line remains invalid.
- Tag RAM is not reset; valid gating makes this safe.

Decomposition:
- Package dcache_pkg:
  - state enum {IDLE, REFILL, WRITE}
  - WORDS_PER_LINE=4, OFFSET_BITS=4
  - address-field extraction functions (tag/index/word)
- One sub-module, dcache_tag_store: valid + tag arrays with async clear, read port and write port.
- The FSM stays in dcache_ctrl.

Test Plan:
- Reset, then load 0x0000_0040 with mem_ready=1:
  - Stall high for 5 cycles.
  - mem_addr steps 0x40, 0x44, 0x48, 0x4C.
  - fill_word 0..3, fill_index=4.
  - Cycle 6: hit=1, stall=0.
- Repeat load at 0x44: hit=1 same cycle, no mem_req.
- Load 0x0000_0440 (same index 4, new tag):
  - Miss; refills from 0x440.
  - A subsequent load at 0x40 misses again.
- Store to 0x48 (hit) with mem_ready delayed 3 cycles:
  - mem_we=1 and stall held for 3 cycles.
  - cache_we pulses once with fill_index=4.
- Store to 0x1000 (miss): mem write only, cache_we=0; a load at 0x1000 then misses.
- Assert rst during the 2nd refill beat: outputs 0 immediately; a load at 0x40 afterwards misses.
- Assert flush in IDLE after a fill: a load at 0x40 then misses.
